ones_frame_accum: RTL and testbench
===================================

Name: ones_frame_accum

Overview:
- Downstream consumer of the 7-bit ones-counter stage; takes its 3-bit per-word population count.
- Groups consecutive counts into frames of FRAME words and produces per-frame statistics: total ones, maximum per-word count and frame length.
- Results leave on a valid/ready output port.
- Input side uses a valid/ready handshake so the block can stall the producer while a result is pending.

Parameters:
- CW, 3, width of count_in (per-word ones count, legal values 0..7).
- FRAME, 8, words per full frame (2..15).
- SUM_W, 6, width of sum_out; must satisfy 2^SUM_W > 7*FRAME, so no overflow is possible.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- count_in  input  CW  ones count of the current word.
- in_valid  input  1  count_in is valid this cycle.
- in_ready  output  1  block accepts count_in this cycle.
- flush  input  1  terminate the current frame early.
- sum_out  output  SUM_W  total ones in the completed frame.
- max_out  output  CW  largest count_in in the completed frame.
- len_out  output  4  number of words in the completed frame (1..FRAME).
- out_valid  output  1  result registers hold an unconsumed frame result.
- out_ready  input  1  consumer takes the result.

Behaviour:
- Reset:
  - Sampled on the clk edge while rst_n=0.
  - FSM goes to ACCUM; word index, running sum and running max are cleared.
  - Outputs: sum_out=0, max_out=0, len_out=0, out_valid=0, in_ready=0 during reset; in_ready=1 on the first cycle after reset releases.
  - Reset mid-frame or mid-HOLD discards all partial and pending results.
- Input accept: a word is accepted when in_valid && in_ready at the rising edge. in_ready is a registered/FSM output, =1 only in ACCUM.
- ACCUM state, on accept:
  - run_sum += count_in (zero-extended to SUM_W).
  - run_max = max(run_max, count_in).
  - idx += 1.
- Frame end (any of):
  - Accepted word with idx == FRAME-1.
  - flush=1 in ACCUM with at least one word in the frame, counting the word accepted in that same cycle.
- On frame end, in the same edge:
  - sum_out, max_out and len_out are loaded with the final values, including the word accepted in that cycle.
  - run_sum, run_max and idx clear.
  - out_valid goes to 1 and the FSM goes to HOLD.
  - Latency: result visible the cycle after the last word's accept edge.
- flush with zero words in the frame and no accept that cycle is ignored; no empty frame is ever emitted.
- flush in HOLD is ignored.
- HOLD state:
  - in_ready=0; sum_out, max_out and len_out stable.
  - On out_valid && out_ready, out_valid goes to 0 next cycle and the FSM returns to ACCUM, so in_ready=1 on that next cycle.
  - out_valid never drops without out_ready.
- Throughput: one word per cycle in ACCUM. Each frame costs at least one extra HOLD cycle.
- count_in > 7 cannot occur with CW=3. Arithmetic is unsigned and never saturates, given the SUM_W constraint.

Test Plan:
- Full frame: counts 0,4,5,7,3,1,6,4 on consecutive cycles with out_ready=1 → one cycle after the 8th accept: out_valid=1, sum_out=30, max_out=7, len_out=8; in_ready=1 again the following cycle.
- Backpressure: repeat the full frame with out_ready=0 for 5 cycles → out_valid and result fields hold; in_ready=0 throughout; a held in_valid word is not consumed until after the out_ready handshake.
- Early flush: counts 2,6,1 with flush asserted alongside the 3rd word → sum_out=9, max_out=6, len_out=3.
- Idle flush: flush=1 for 3 cycles with in_valid=0 and an empty frame → out_valid stays 0, state unchanged.
- Reset mid-frame: accept 5 words, assert rst_n=0 for one cycle, then send 8 counts of 1 → only sum_out=8, max_out=1, len_out=8 is reported; outputs read 0 immediately after reset.
- Input gaps: the full-frame vector with in_valid dropped on alternate cycles → same result as the full-frame test (30/7/8).

Source files
------------

// File: rtl/ones_frame_accum_if.sv
// Handshake bundle between the ones-counter stage, the frame accumulator and
// the frame-statistics consumer.
interface ones_frame_accum_if #(
  parameter int CW    = 3,
  parameter int SUM_W = 6
);
  logic [CW-1:0]    count_in;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [SUM_W-1:0] sum_out;
  logic [CW-1:0]    max_out;
  logic [3:0]       len_out;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  count_in, in_valid, flush, out_ready,
    output in_ready, sum_out, max_out, len_out, out_valid
  );

  modport master (
    output count_in, in_valid, flush, out_ready,
    input  in_ready, sum_out, max_out, len_out, out_valid
  );
endinterface

// File: rtl/ones_frame_accum.sv
// Groups per-word ones counts into frames and reports sum, max and length
// of each frame; the producer is stalled while a result waits for the consumer.
module ones_frame_accum #(
  parameter int CW    = 3,
  parameter int FRAME = 8,
  parameter int SUM_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  ones_frame_accum_if.slave  bus
);
  typedef enum logic {ACCUM, HOLD} state_e;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d, len_q, len_d;
  logic [SUM_W-1:0] run_sum_q, run_sum_d, sum_q, sum_d;
  logic [CW-1:0]    run_max_q, run_max_d, max_q, max_d;
  logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d;

  logic             accept, frame_end;
  logic [SUM_W-1:0] sum_nxt;
  logic [CW-1:0]    max_nxt;
  logic [3:0]       idx_nxt;

  // in_ready_q comes out of reset high; gating keeps it low while reset is held
  assign bus.in_ready  = in_ready_q & rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.sum_out   = sum_q;
  assign bus.max_out   = max_q;
  assign bus.len_out   = len_q;

  assign accept = bus.in_valid & bus.in_ready;

  always_comb begin
    sum_nxt   = run_sum_q + (accept ? SUM_W'(bus.count_in) : '0);
    max_nxt   = (accept && (bus.count_in > run_max_q)) ? bus.count_in : run_max_q;
    idx_nxt   = idx_q + {3'b000, accept};
    // flush counts the word accepted alongside it, so empty frames never close
    frame_end = (state_q == ACCUM) &&
                ((accept && (idx_q == 4'(FRAME - 1))) || (bus.flush && (idx_nxt != 4'd0)));

    state_d     = state_q;
    idx_d       = idx_q;
    run_sum_d   = run_sum_q;
    run_max_d   = run_max_q;
    sum_d       = sum_q;
    max_d       = max_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      ACCUM: begin
        if (frame_end) begin
          sum_d       = sum_nxt;
          max_d       = max_nxt;
          len_d       = idx_nxt;
          run_sum_d   = '0;
          run_max_d   = '0;
          idx_d       = 4'd0;
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
          state_d     = HOLD;
        end else begin
          run_sum_d = sum_nxt;
          run_max_d = max_nxt;
          idx_d     = idx_nxt;
        end
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      idx_q       <= 4'd0;
      run_sum_q   <= '0;
      run_max_q   <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      len_q       <= 4'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      run_sum_q   <= run_sum_d;
      run_max_q   <= run_max_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end
endmodule

// File: tb/tb_ones_frame_accum.sv
// Bench for ones_frame_accum: queue-based frame model checked every cycle,
// directed frames with literal results, then a randomized run.
module tb_ones_frame_accum;
  localparam int CW = 3, FRAME = 8, SUM_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ones_frame_accum_if #(.CW(CW), .SUM_W(SUM_W)) bus ();

  ones_frame_accum #(.CW(CW), .FRAME(FRAME), .SUM_W(SUM_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // model: words of the open frame, plus the last reported result
  int q[$];
  bit pend = 0, started = 0;
  int m_sum = 0, m_max = 0, m_len = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete(); pend = 0; m_sum = 0; m_max = 0; m_len = 0; started = 1;
    end else if (pend) begin
      if (bus.out_ready) pend = 0;
    end else begin
      if (bus.in_valid) q.push_back(int'(bus.count_in));
      if (q.size() == FRAME || (bus.flush && q.size() > 0)) begin
        m_sum = 0; m_max = 0; m_len = q.size();
        foreach (q[i]) begin
          m_sum += q[i];
          if (q[i] > m_max) m_max = q[i];
        end
        pend = 1;
        q.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      total++;
      if (bus.in_ready !== (rst_n && !pend) || bus.out_valid !== pend ||
          int'(bus.sum_out) != m_sum || int'(bus.max_out) != m_max ||
          int'(bus.len_out) != m_len || $isunknown({bus.sum_out, bus.max_out, bus.len_out})) begin
        bad++;
        $display("FAIL model t=%0t: rdy=%b vld=%b sum=%0d max=%0d len=%0d, expected rdy=%b vld=%b sum=%0d max=%0d len=%0d",
                 $time, bus.in_ready, bus.out_valid, bus.sum_out, bus.max_out, bus.len_out,
                 rst_n && !pend, pend, m_sum, m_max, m_len);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // holds the word until the block takes it; called at posedge+1
  task automatic drive_word(input int c, input bit fl);
    int n = 0;
    bus.in_valid = 1'b1; bus.count_in = 3'(c); bus.flush = fl;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        bad++; total++;
        $display("FAIL accept_timeout: word %0d not taken, in_ready=%b", c, bus.in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic chk_result(input string nm, input int s, input int m, input int l);
    @(negedge clk);
    chk({nm, "_vld"}, int'(bus.out_valid), 1);
    chk({nm, "_sum"}, int'(bus.sum_out), s);
    chk({nm, "_max"}, int'(bus.max_out), m);
    chk({nm, "_len"}, int'(bus.len_out), l);
  endtask

  int full_v[8] = '{0, 4, 5, 7, 3, 1, 6, 4};

  initial begin
    bus.in_valid = 0; bus.count_in = 0; bus.flush = 0; bus.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_in_ready", int'(bus.in_ready), 0);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1 rst_n = 1;

    // full frame
    foreach (full_v[i]) drive_word(full_v[i], 0);
    chk_result("full", 30, 7, 8);
    @(negedge clk);
    chk("full_rdy_again", int'(bus.in_ready), 1);
    @(posedge clk); #1;

    // backpressure, with a word held on the input
    bus.out_ready = 0;
    foreach (full_v[i]) drive_word(full_v[i], 0);
    bus.in_valid = 1; bus.count_in = 3'd5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_vld", int'(bus.out_valid), 1);
      chk("bp_rdy", int'(bus.in_ready), 0);
      chk("bp_sum", int'(bus.sum_out), 30);
    end
    @(posedge clk); #1;
    bus.out_ready = 1;
    drive_word(5, 0);
    drive_word(2, 1);
    chk_result("bp_next", 7, 5, 2);
    @(posedge clk); #1;

    // early flush
    drive_word(2, 0); drive_word(6, 0); drive_word(1, 1);
    chk_result("flush", 9, 6, 3);
    @(posedge clk); #1;

    // idle flush on an empty frame
    bus.flush = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_flush_vld", int'(bus.out_valid), 0);
    end
    @(posedge clk); #1 bus.flush = 0;

    // reset mid-frame
    for (int k = 0; k < 5; k++) drive_word(7, 0);
    rst_n = 0;
    @(negedge clk);
    chk("rst_rdy_low", int'(bus.in_ready), 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("rst_sum0", int'(bus.sum_out), 0);
    chk("rst_len0", int'(bus.len_out), 0);
    chk("rst_rdy1", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) drive_word(1, 0);
    chk_result("post_rst", 8, 1, 8);
    @(posedge clk); #1;

    // gaps between words
    foreach (full_v[i]) begin
      drive_word(full_v[i], 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("gaps_sum", int'(bus.sum_out), 30);
    chk("gaps_max", int'(bus.max_out), 7);
    chk("gaps_len", int'(bus.len_out), 8);
    @(posedge clk); #1;

    // randomized traffic with occasional reset
    repeat (3000) begin
      rst_n         = ($urandom_range(0, 199) != 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.count_in  = 3'($urandom_range(0, 7));
      bus.flush     = ($urandom_range(0, 7) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    rst_n = 1; bus.in_valid = 0; bus.flush = 0; bus.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
